multisim_client_push_packer: RTL

Upstream feeder for the multisim push client: accepts narrow DUT beats over a valid/ready handshake, packs `PACK_RATIO` beats into one `DATA_WIDTH` word, and buffers completed words in a small FIFO. Its output drives the push client's `data_vld`/`data` inputs and obeys its `data_rdy`. This decouples the DUT from DPI backpressure, which appears when the server is not ready.

---
 rtl/multisim_client_push_packer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/multisim_client_push_packer.sv
// Packs narrow DUT beats into DATA_WIDTH words and buffers them for the push client.
// Optional statistics counters are built when MULTISIM_PACKER_STATS_EN is defined.
module multisim_client_push_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int PACK_RATIO = 8,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
    output logic                  data_vld,
    input  logic                  data_rdy,
    output logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           words_sent
);

    localparam int LW = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (DATA_WIDTH != IN_WIDTH * PACK_RATIO) begin : g_bad_width
        $fatal(1, "DATA_WIDTH must equal IN_WIDTH*PACK_RATIO");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "FIFO_DEPTH must be a power of two >= 2");
    end

    logic [LW-1:0]         lane;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic                  accept;
    logic                  complete;
    logic                  pop;

    assign in_rdy   = !rst && (count != (PW+1)'(FIFO_DEPTH));
    assign accept   = in_vld && in_rdy;
    assign complete = accept && ((lane == LW'(PACK_RATIO - 1)) || in_last);
    assign data_vld = (count != '0);
    assign pop      = data_vld && data_rdy;
    assign data     = data_vld ? mem[rd_ptr] : '0;

    // Drop the incoming beat into its lane on top of the pending partial word.
    always_comb begin
        merged = asm_word;
        merged[lane*IN_WIDTH +: IN_WIDTH] = in_data;
    end

    // Lane counter and assembly register; both restart after each completed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane     <= '0;
            asm_word <= '0;
        end else if (accept) begin
            if (complete) begin
                lane     <= '0;
                asm_word <= '0;
            end else begin
                lane     <= lane + 1'b1;
                asm_word <= merged;
            end
        end
    end

    // Word storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (complete) begin
            mem[wr_ptr] <= merged;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (complete) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({complete, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MULTISIM_PACKER_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] sent_q;

    // Stall cycles saturate; sent words wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            sent_q  <= '0;
        end else begin
            if (data_vld && !data_rdy && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
            if (pop) begin
                sent_q <= sent_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign words_sent   = sent_q;
`else
    assign stall_cycles = '0;
    assign words_sent   = '0;
`endif

endmodule
